// File: rtl/clk_div_ctrl.sv
// Sequencing controller for the reference-clock divider: drain, reload, settle, lock.
// Optional build macro CLK_DIV_CTRL_SKIP_SAME_EN: ignore same-ratio updates while locked.
module clk_div_ctrl #(
  parameter logic [7:0]  RST_RATIO = 8'd1,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic       i_cfg_valid,
  input  logic [7:0] i_cfg_ratio,
  output logic       o_cfg_ready,
  output logic [7:0] o_div_ratio,
  output logic       o_clk_en,
  output logic       o_locked,
  output logic       o_busy,
  output logic       o_err
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4
  } state_e;

  localparam logic [8:0] DRAIN_INIT = 9'(DRAIN_CYC);

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] ratio_q, ratio_d;
  logic [8:0] cnt_q, cnt_d;
  logic       ready_q, clk_en_q, locked_q, busy_q, err_q;

  logic accept_s, acc_zero_s, acc_new_s, same_s;

  // Handshake decode: zero ratios are consumed but rejected.
  always_comb begin
    accept_s   = i_cfg_valid & ready_q;
    acc_zero_s = accept_s & (i_cfg_ratio == 8'd0);
`ifdef CLK_DIV_CTRL_SKIP_SAME_EN
    same_s     = (state_q == ST_LOCKED) & (i_cfg_ratio == ratio_q);
`else
    same_s     = 1'b0;
`endif
    acc_new_s  = accept_s & ~acc_zero_s & ~same_s;
    if (acc_new_s) begin
      pending_d = i_cfg_ratio;
    end else begin
      pending_d = pending_q;
    end
  end

  // Next-state logic; the divider ratio only moves while the enable is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    case (state_q)
      ST_OFF: begin
        if (i_run) begin
          state_d = ST_LOAD;
          ratio_d = pending_d;
        end else if (acc_new_s) begin
          ratio_d = i_cfg_ratio;
        end else begin
          ratio_d = ratio_q;
        end
      end
      ST_LOAD: begin
        cnt_d = {pending_q, 1'b0};
        if (pending_q == 8'd1) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!i_run) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_INIT;
        end else if (cnt_q == 9'd1) begin
          state_d = ST_LOCKED;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      ST_LOCKED: begin
        if (acc_new_s || !i_run) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_INIT;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 9'd1) begin
          ratio_d = pending_q;
          if (i_run) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // State, pending ratio and Moore outputs decoded from the next state.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_OFF;
      pending_q <= RST_RATIO;
      ratio_q   <= RST_RATIO;
      cnt_q     <= 9'd0;
      ready_q   <= 1'b1;
      clk_en_q  <= 1'b0;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ratio_q   <= ratio_d;
      cnt_q     <= cnt_d;
      ready_q   <= (state_d == ST_OFF) || (state_d == ST_LOCKED);
      clk_en_q  <= (state_d == ST_SETTLE) || (state_d == ST_LOCKED);
      locked_q  <= (state_d == ST_LOCKED);
      busy_q    <= (state_d == ST_DRAIN) || (state_d == ST_LOAD) || (state_d == ST_SETTLE);
      err_q     <= acc_zero_s;
    end
  end

  assign o_cfg_ready = ready_q;
  assign o_div_ratio = ratio_q;
  assign o_clk_en    = clk_en_q;
  assign o_locked    = locked_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (RST_RATIO=1, DRAIN_CYC=4).
module tb_clk_div_ctrl;

  logic       i_ref_clk;
  logic       i_rst_n;
  logic       i_run;
  logic       i_cfg_valid;
  logic [7:0] i_cfg_ratio;
  logic       o_cfg_ready;
  logic [7:0] o_div_ratio;
  logic       o_clk_en;
  logic       o_locked;
  logic       o_busy;
  logic       o_err;

  int checks = 0;
  int errors = 0;

  // status = {clk_en, locked, busy, ready, err}
  localparam logic [4:0] S_OFF    = 5'b00010;
  localparam logic [4:0] S_DRAIN  = 5'b00100;
  localparam logic [4:0] S_SETTLE = 5'b10100;
  localparam logic [4:0] S_LOCKED = 5'b11010;
  localparam logic [4:0] S_LK_ERR = 5'b11011;

  wire logic [4:0] st = {o_clk_en, o_locked, o_busy, o_cfg_ready, o_err};

  clk_div_ctrl #(.RST_RATIO(8'd1), .DRAIN_CYC(4)) dut (
    .i_ref_clk  (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_run      (i_run),
    .i_cfg_valid(i_cfg_valid),
    .i_cfg_ratio(i_cfg_ratio),
    .o_cfg_ready(o_cfg_ready),
    .o_div_ratio(o_div_ratio),
    .o_clk_en   (o_clk_en),
    .o_locked   (o_locked),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  initial i_ref_clk = 1'b0;
  always #5 i_ref_clk = ~i_ref_clk;

  task automatic tick();
    @(posedge i_ref_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_run = 1'b0; i_cfg_valid = 1'b0; i_cfg_ratio = 8'd0;
    tick(); tick();
    checks++;
    if (st !== S_OFF) begin
      errors++; $display("FAIL reset_status got %b exp %b", st, S_OFF);
    end
    checks++;
    if (o_div_ratio !== 8'd1) begin
      errors++; $display("FAIL reset_ratio got %0d exp 1", o_div_ratio);
    end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_run_up(input string nm);
    i_run = 1'b1;
    tick();
    checks++;
    if (st !== S_DRAIN) begin
      errors++; $display("FAIL %s_load got %b exp %b", nm, st, S_DRAIN);
    end
    tick();
    checks++;
    if (st !== S_LOCKED || o_div_ratio !== 8'd1) begin
      errors++; $display("FAIL %s_locked got %b/%0d exp %b/1", nm, st, o_div_ratio, S_LOCKED);
    end
  endtask

  // Accept r while locked: 5 cycles enable-low, then 2r settle cycles.
  task automatic test_reconfig(input logic [7:0] r, input string nm);
    i_cfg_valid = 1'b1; i_cfg_ratio = r;
    tick();
    i_cfg_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      checks++;
      if (st !== S_DRAIN) begin
        errors++; $display("FAIL %s_drain k=%0d got %b exp %b", nm, k, st, S_DRAIN);
      end
    end
    tick();
    checks++;
    if (st !== S_SETTLE || o_div_ratio !== r) begin
      errors++; $display("FAIL %s_enable got %b/%0d exp %b/%0d", nm, st, o_div_ratio, S_SETTLE, r);
    end
    for (int k = 6; k < 17; k++) begin
      tick();
      checks++;
      if (st !== S_SETTLE) begin
        errors++; $display("FAIL %s_settle k=%0d got %b exp %b", nm, k, st, S_SETTLE);
      end
    end
    tick();
    checks++;
    if (st !== S_LOCKED || o_div_ratio !== r) begin
      errors++; $display("FAIL %s_lock got %b/%0d exp %b/%0d", nm, st, o_div_ratio, S_LOCKED, r);
    end
  endtask

  task automatic test_zero_reject();
    i_cfg_valid = 1'b1; i_cfg_ratio = 8'd0;
    tick();
    i_cfg_valid = 1'b0;
    checks++;
    if (st !== S_LK_ERR || o_div_ratio !== 8'd6) begin
      errors++; $display("FAIL zero_err got %b/%0d exp %b/6", st, o_div_ratio, S_LK_ERR);
    end
    tick();
    checks++;
    if (st !== S_LOCKED || o_div_ratio !== 8'd6) begin
      errors++; $display("FAIL zero_after got %b/%0d exp %b/6", st, o_div_ratio, S_LOCKED);
    end
  endtask

  task automatic test_same_ratio();
`ifdef CLK_DIV_CTRL_SKIP_SAME_EN
    i_cfg_valid = 1'b1; i_cfg_ratio = 8'd6;
    for (int k = 0; k < 20; k++) begin
      tick();
      i_cfg_valid = 1'b0;
      checks++;
      if (st !== S_LOCKED || o_div_ratio !== 8'd6) begin
        errors++; $display("FAIL same_skip k=%0d got %b/%0d exp %b/6", k, st, o_div_ratio, S_LOCKED);
      end
    end
`else
    test_reconfig(8'd6, "same");
`endif
  endtask

  task automatic test_ratio_and_stop();
    i_cfg_valid = 1'b1; i_cfg_ratio = 8'd9; i_run = 1'b0;
    tick();
    i_cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checks++;
      if (st !== S_DRAIN) begin
        errors++; $display("FAIL stop_drain k=%0d got %b exp %b", k, st, S_DRAIN);
      end
    end
    tick();
    checks++;
    if (st !== S_OFF || o_div_ratio !== 8'd9) begin
      errors++; $display("FAIL stop_off got %b/%0d exp %b/9", st, o_div_ratio, S_OFF);
    end
  endtask

  task automatic test_off_direct();
    i_cfg_valid = 1'b1; i_cfg_ratio = 8'd3;
    tick();
    i_cfg_valid = 1'b0;
    checks++;
    if (st !== S_OFF || o_div_ratio !== 8'd3) begin
      errors++; $display("FAIL off_direct got %b/%0d exp %b/3", st, o_div_ratio, S_OFF);
    end
  endtask

  task automatic test_reset_in_settle();
    i_cfg_valid = 1'b1; i_cfg_ratio = 8'd200; i_run = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    checks++;
    if (st !== S_DRAIN || o_div_ratio !== 8'd200) begin
      errors++; $display("FAIL rst_load got %b/%0d exp %b/200", st, o_div_ratio, S_DRAIN);
    end
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (st !== S_SETTLE || o_div_ratio !== 8'd200) begin
      errors++; $display("FAIL rst_settle got %b/%0d exp %b/200", st, o_div_ratio, S_SETTLE);
    end
    #2;
    i_rst_n = 1'b0; i_run = 1'b0;
    #1;
    checks++;
    if (st !== S_OFF || o_div_ratio !== 8'd1) begin
      errors++; $display("FAIL rst_async got %b/%0d exp %b/1", st, o_div_ratio, S_OFF);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_run_up("runup");
    test_reconfig(8'd6, "ratio6");
    test_zero_reject();
    test_same_ratio();
    test_ratio_and_stop();
    test_off_direct();
    test_reset_in_settle();
    test_run_up("rerun");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Sequencing controller for the integer reference-clock divider. It accepts divide-ratio updates from the register file over a valid/ready handshake. Each change is applied glitch-safely: the divider is disabled, drained, reloaded, re-enabled, and lock is reported only after a settle window. It sits between the register file and the divider's `i_clk_en` / `i_div_ratio` inputs, and its `o_locked` gates UART activity.

## Interface
- `RST_RATIO`, default 8'd1: `o_div_ratio` value out of reset (1 = bypass).
- `DRAIN_CYC`, default 4: ref cycles the divider is held disabled before a reload. Legal range 1..15.
- `i_ref_clk` in 1: reference clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_run` in 1: 1 = keep the divider enabled; 0 = shut it down.
- `i_cfg_valid` in 1: ratio update request.
- `i_cfg_ratio` in 8: requested divide ratio.
- `o_cfg_ready` in 1 → out 1: controller can accept an update.
- `o_div_ratio` out 8: ratio driven to the divider.
- `o_clk_en` out 1: divider enable.
- `o_locked` out 1: divided clock stable at `o_div_ratio`.
- `o_busy` out 1: reconfiguration in progress.
- `o_err` out 1: one-cycle pulse when ratio 0 is rejected.

## Operation
- All outputs are registered Moore outputs.
- Reset values:
  - `o_div_ratio` = `RST_RATIO`.
  - `o_clk_en` = 0, `o_locked` = 0, `o_busy` = 0, `o_err` = 0.
  - `o_cfg_ready` = 1.
  - State = OFF, pending = `RST_RATIO`, counter = 0.
- Accept occurs when `i_cfg_valid` && `o_cfg_ready`. `o_cfg_ready` = 1 only in OFF and LOCKED.
- Accepting ratio 0: `o_err` pulses next cycle, no state change, pending unchanged; the request is consumed.
- Accepting a nonzero ratio latches it into pending.
- FSM states: OFF, DRAIN, LOAD, SETTLE, LOCKED.
- OFF (`o_clk_en` = 0, `o_locked` = 0):
  - Nonzero accept with `i_run` = 0: `o_div_ratio` ← ratio directly; stay in OFF.
  - `i_run` = 1 → LOAD (includes an accept in the same cycle).
- LOAD, one cycle, `o_clk_en` = 0:
  - `o_div_ratio` ← pending.
  - Counter ← 2·pending (9 bits; 510 max).
  - → SETTLE, or → LOCKED if pending = 1.
- SETTLE (`o_clk_en` = 1, `o_busy` = 1): counter decrements each cycle; at counter = 1 → LOCKED.
- LOCKED (`o_clk_en` = 1, `o_locked` = 1):
  - Nonzero accept → DRAIN.
  - `i_run` = 0 → DRAIN.
  - Both in the same cycle: ratio latched, → DRAIN.
- DRAIN (`o_clk_en` = 0, `o_locked` = 0, `o_busy` = 1): count `DRAIN_CYC` cycles, then:
  - `i_run` = 1 → LOAD.
  - Otherwise `o_div_ratio` ← pending and → OFF.
- `i_run` deasserted in SETTLE: → DRAIN immediately.
- `i_cfg_valid` in DRAIN/LOAD/SETTLE: held off by ready = 0; the requester must hold valid and data stable.
- Async reset mid-sequence returns all outputs to reset values within the same cycle.

## Timing
- Accept in LOCKED at edge e0 gives:
  - DRAIN for e0..e0+`DRAIN_CYC`−1.
  - LOAD at e0+`DRAIN_CYC`.
  - `o_clk_en` = 1 and new `o_div_ratio` from e0+`DRAIN_CYC`+1.
  - `o_locked` = 1 from e0+`DRAIN_CYC`+1+2R (R = 1: from e0+`DRAIN_CYC`+1).
- `o_div_ratio` never changes while `o_clk_en` = 1.
- `o_clk_en` is low for ≥ `DRAIN_CYC`+1 cycles around every ratio change.
- OFF with `i_run` rising at edge e0: `o_clk_en` = 1 at e0+2 (LOAD at e0+1).

## Configuration
- `CLK_DIV_CTRL_SKIP_SAME_EN`:
  - Defined: in LOCKED, accepting a ratio equal to `o_div_ratio` is acknowledged with no state change; `o_clk_en` / `o_locked` stay high, with no disruption.
  - Undefined: every nonzero accept in LOCKED runs the full DRAIN/LOAD/SETTLE sequence.

## Test plan
- Reset with `RST_RATIO` = 1 and `DRAIN_CYC` = 4, then `i_run` = 1 → `o_clk_en` = 1 two cycles later; `o_locked` = 1 on the same edge, `o_div_ratio` = 1.
- From LOCKED, accept ratio 6 → `o_clk_en` low for exactly 5 cycles, `o_div_ratio` = 6 when `o_clk_en` rises, `o_locked` after 12 more cycles; ready low throughout.
- Accept ratio 0 in LOCKED → `o_err` one-cycle pulse, `o_clk_en` / `o_locked` unchanged, ratio unchanged.
- Accept ratio 9 and drop `i_run` in the same cycle → DRAIN 4 cycles, then OFF with `o_div_ratio` = 9, `o_clk_en` = 0, ready = 1.
- `i_rst_n` asserted during SETTLE with ratio 200 → outputs immediately at reset values.
- Accept the same ratio 6 in LOCKED → with `CLK_DIV_CTRL_SKIP_SAME_EN`, `o_clk_en` never drops; without it, the full 5 + 12-cycle sequence runs.
